// File: rtl/spi_master_arbiter.sv
// rtl/spi_master_arbiter.sv - round-robin arbitrated SPI master (CPOL=0, CPHA=0) shared by NUM_REQ requesters
//
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   req      per-requester level request, held until done
//   tx_data  byte for requester i at bits [8i+7:8i], captured at grant
//   grant    registered one-hot owner of the transfer in progress
//   done     one-cycle pulse when the owner's byte exchange is complete
//   rx_data  byte received on miso, updated with done and held until the next done
//   busy     high whenever the controller is not idle
//   sclk     SPI clock, idles low
//   ss_n     active-low slave selects, ss_n[i] belongs to requester i
//   mosi     serial data out, MSB first
//   miso     serial data in, MSB first
module spi_master_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int CLK_DIV = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   tx_data,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   done,
    output logic [7:0]             rx_data,
    output logic                   busy,
    output logic                   sclk,
    output logic [NUM_REQ-1:0]     ss_n,
    output logic                   mosi,
    input  logic                   miso
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int IW = PW + 1;
    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(NUM_REQ - 1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_XFER, S_HOLD, S_GAP} state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [DW-1:0]      r_div_cnt;
    logic [2:0]         r_bit_cnt;
    logic [PW-1:0]      r_rr_ptr;
    logic [PW-1:0]      r_winner;
    logic [6:0]         r_tx_sh;
    logic [7:0]         r_rx_sh;
    logic [7:0]         r_rx_data;
    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] r_ss_n;
    logic               r_sclk;
    logic               r_mosi;
    logic               r_done;

    logic [PW-1:0]      w_winner;
    logic [IW-1:0]      w_idx;
    logic [7:0]         w_tx_sel;
    logic               w_start;
    logic               w_div_last;
    logic               w_rise;
    logic               w_fall;
    logic               w_last_bit;

    // Round-robin search: scan offsets from the highest down so that the
    // requester closest above r_rr_ptr (with wrap) is the last one written.
    always_comb begin
        w_winner = '0;
        w_idx    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = {1'b0, r_rr_ptr} + IW'(k);
            if (w_idx >= IW'(NUM_REQ)) begin
                w_idx = w_idx - IW'(NUM_REQ);
            end
            if (req[w_idx[PW-1:0]]) begin
                w_winner = w_idx[PW-1:0];
            end
        end
    end

    assign w_tx_sel   = tx_data[{w_winner, 3'b000} +: 8];
    assign w_start    = (r_state == S_IDLE) && (|req);
    assign w_div_last = (r_div_cnt == DIV_LAST);
    assign w_rise     = (r_state == S_XFER) && w_div_last && !r_sclk;
    assign w_fall     = (r_state == S_XFER) && w_div_last && r_sclk;
    assign w_last_bit = (r_bit_cnt == 3'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (|req)                  w_next_state = S_SETUP;
            S_SETUP: if (w_div_last)            w_next_state = S_XFER;
            S_XFER:  if (w_fall && w_last_bit)  w_next_state = S_HOLD;
            S_HOLD:  if (w_div_last)            w_next_state = S_GAP;
            S_GAP:   if (w_div_last)            w_next_state = S_IDLE;
            default:                            w_next_state = S_IDLE;
        endcase
    end

    // Half-period counter restarts on every state entry and at the end of
    // each sclk phase; the bit counter advances on each falling sclk edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
        end else begin
            if ((r_state == S_IDLE) || (w_next_state != r_state) || w_div_last) begin
                r_div_cnt <= '0;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end
            if (w_next_state != r_state) begin
                r_bit_cnt <= '0;
            end else if (w_fall) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr  <= '0;
            r_winner  <= '0;
            r_tx_sh   <= '0;
            r_rx_sh   <= '0;
            r_rx_data <= '0;
            r_grant   <= '0;
            r_ss_n    <= '1;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_start) begin
                // MSB goes straight onto mosi; the remaining 7 bits are kept
                // so later tx_data changes cannot disturb this transfer.
                r_winner <= w_winner;
                r_grant  <= NUM_REQ'(1) << w_winner;
                r_ss_n   <= ~(NUM_REQ'(1) << w_winner);
                r_mosi   <= w_tx_sel[7];
                r_tx_sh  <= w_tx_sel[6:0];
            end
            if (w_rise) begin
                r_sclk  <= 1'b1;
                r_rx_sh <= {r_rx_sh[6:0], miso};
            end
            if (w_fall) begin
                r_sclk <= 1'b0;
                if (!w_last_bit) begin
                    r_mosi  <= r_tx_sh[6];
                    r_tx_sh <= {r_tx_sh[5:0], 1'b0};
                end
            end
            if ((r_state == S_HOLD) && w_div_last) begin
                r_ss_n    <= '1;
                r_grant   <= '0;
                r_mosi    <= 1'b0;
                r_rx_data <= r_rx_sh;
                r_done    <= 1'b1;
                r_rr_ptr  <= (r_winner == PTR_LAST) ? '0 : r_winner + 1'b1;
            end
        end
    end

    assign grant   = r_grant;
    assign done    = r_done;
    assign rx_data = r_rx_data;
    assign busy    = (r_state != S_IDLE);
    assign sclk    = r_sclk;
    assign ss_n    = r_ss_n;
    assign mosi    = r_mosi;

endmodule

// File: doc/spi_master_arbiter.md
SPI_MASTER_ARBITER -- requirements
Module: spi_master_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning number of requesters and slave-select lines (2..8).
REQ-002 SHALL have parameter CLK_DIV, default 4, meaning clk cycles per SCLK half-period (min 4).
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  input  NUM_REQ  per-requester transfer request, level, held until done.
REQ-006 SHALL have port tx_data  input  8*NUM_REQ  byte for requester i at bits [8i+7:8i].
REQ-007 SHALL have port grant  output  NUM_REQ  one-hot owner of the current transfer, registered.
REQ-008 SHALL have port done  output  1  single-cycle pulse, transfer of the granted requester complete.
REQ-009 SHALL have port rx_data  output  8  byte received on miso, valid when done=1, held until next done.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port sclk  output  1  SPI clock, CPOL=0, CPHA=0, registered.
REQ-012 SHALL have port ss_n  output  NUM_REQ  active-low slave selects, ss_n[i] belongs to requester i.
REQ-013 SHALL have port mosi  output  1  serial data out, MSB first, registered.
REQ-014 SHALL have port miso  input  1  serial data in, MSB first.

Function
REQ-015 SHALL implement states IDLE, SETUP, XFER, HOLD, GAP.
REQ-016 IDLE: if req!=0, SHALL pick winner by round-robin, searching upward from pointer rr_ptr with wrap; next edge: grant=onehot(winner), ss_n[winner]=0, mosi=tx_data[winner][7], latch tx byte, enter SETUP.
REQ-017 Requester-to-ss_n latency SHALL be exactly 1 clk from the IDLE cycle sampling req.
REQ-018 SETUP SHALL last CLK_DIV cycles with sclk=0, then enter XFER.
REQ-019 XFER SHALL run 8 bits, each CLK_DIV cycles sclk=0 then CLK_DIV cycles sclk=1 (16*CLK_DIV cycles total).
REQ-020 On each sclk 0->1 transition, miso SHALL be shifted into the rx shift register (sampled in the same clk cycle sclk is registered high).
REQ-021 On each sclk 1->0 transition for bits 1..7, mosi SHALL advance to the next lower tx bit; after bit 0's high phase, mosi holds.
REQ-022 After the 8th high phase, SHALL enter HOLD with sclk=0, ss_n[winner]=0, for CLK_DIV cycles.
REQ-023 Leaving HOLD, SHALL set all ss_n=1, mosi=0, grant=0, rx_data=shift register, done=1 for one cycle, rr_ptr=(winner+1) mod NUM_REQ, enter GAP.
REQ-024 GAP SHALL last CLK_DIV cycles with all ss_n=1 and sclk=0, then enter IDLE; req is not sampled in GAP.
REQ-025 At most one ss_n bit SHALL be low at any time; sclk SHALL toggle only in XFER.
REQ-026 Deassertion of req[winner] mid-transfer SHALL be ignored; the transfer completes normally.
REQ-027 Changes of tx_data after the IDLE grant cycle SHALL not affect the transfer in progress.
REQ-028 Total ss_n low time per transfer SHALL be (18*CLK_DIV) cycles; IDLE-to-IDLE = 19*CLK_DIV+1 cycles.
REQ-029 Half-period and bit counters SHALL be sized for CLK_DIV and 8 bits, wrapping to 0 at each state entry.

Reset
REQ-030 While rst_n=0, SHALL force state=IDLE, grant=0, done=0, rx_data=0x00, busy=0, sclk=0, ss_n=all ones, mosi=0, rr_ptr=0, counters=0.
REQ-031 Reset asserted mid-transfer SHALL deassert ss_n immediately (asynchronously) with no done pulse; first request after release restarts at rr_ptr=0.

Verification
REQ-032 NUM_REQ=4, CLK_DIV=4, req=0100, tx byte 0xA5, slave returns 0x3C -> ss_n=1011 for 72 cycles, slave receives 0xA5, done pulse, rx_data=0x3C.
REQ-033 req=1111 held, all bytes distinct -> grant sequence 0001,0010,0100,1000,0001, each transfer 77 cycles IDLE-to-IDLE.
REQ-034 req=0010 dropped 10 cycles after grant -> transfer still completes, done asserted, rx_data valid, ss_n[1] low 72 cycles.
REQ-035 rst_n pulsed low during bit 4 of XFER -> ss_n=1111, sclk=0, mosi=0, no done; next req=0001 -> normal 0x.. transfer from IDLE.
REQ-036 req=1000 then req=1001 after completion -> rr_ptr=0 grants requester 0; then requester 3 next.
REQ-037 tx_data changed during XFER -> mosi bit stream equals byte latched at grant; sclk shows exactly 8 rising edges per transfer.
